// File: rtl/uart_imem_loader_if.sv
// Instruction-memory write port driven by the serial boot loader.
interface uart_imem_loader_if;
    logic        imem_wr_en;
    logic [31:0] imem_wr_addr;
    logic [31:0] imem_wr_data;

    modport master (output imem_wr_en, output imem_wr_addr, output imem_wr_data);
    modport slave  (input  imem_wr_en, input  imem_wr_addr, input  imem_wr_data);
endinterface

// File: rtl/uart_imem_loader.sv
// UART 8N1 boot loader: receives a framed program image, writes it into instruction memory
// and releases the core from reset once the image checksum has been accepted.
module uart_imem_loader #(
    parameter int CLK_HZ         = 12000000,
    parameter int BAUD           = 115200,
    parameter int IMEM_WORDS     = 2048,
    parameter int TIMEOUT_CYCLES = 1200000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       uart_rx,
    output logic                       core_reset,
    output logic                       load_done,
    output logic                       load_error,
    uart_imem_loader_if.master         imem
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR} state_t;

    rx_state_t   rx_state;
    logic        rx_meta, rx_sync, rx_prev;
    logic [15:0] rx_cnt;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_shift;
    logic        rx_valid, rx_ferr;

    state_t      state, state_next;
    logic [7:0]  len_lo;
    logic [15:0] word_count, word_idx;
    logic [1:0]  byte_cnt;
    logic [31:0] word_buf;
    logic [7:0]  checksum;
    logic [31:0] tmo_cnt;
    logic        active, timeout;
    logic [15:0] len_full;

    // Receiver: edge-triggered start, mid-bit sampling, strobes issued the cycle after the stop sample
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_meta  <= uart_rx;
            rx_sync  <= rx_meta;
            rx_prev  <= rx_sync;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        rx_state <= RX_START;
                        rx_cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (rx_cnt == 16'(HALF_BIT - 1)) begin
                        rx_cnt <= '0;
                        rx_bit <= '0;
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == 16'(CLKS_PER_BIT - 1)) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                        rx_bit <= rx_bit + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == 16'(CLKS_PER_BIT - 1)) begin
                        rx_cnt   <= '0;
                        rx_valid <= rx_sync;
                        rx_ferr  <= !rx_sync;
                        rx_state <= RX_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    assign active   = (state == LEN_LO) || (state == LEN_HI) || (state == DATA) || (state == CHECK);
    assign timeout  = active && (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));
    assign len_full = {rx_shift, len_lo};

    // Frame parser next-state logic; errors in the middle of a frame take priority over bytes
    always_comb begin
        state_next = state;
        if (active && (rx_ferr || timeout)) begin
            state_next = ERROR;
        end else if (rx_valid) begin
            case (state)
                IDLE, ERROR: if (rx_shift == 8'hA5) state_next = LEN_LO;
                LEN_LO:      state_next = LEN_HI;
                LEN_HI: begin
                    if (32'(len_full) > 32'(IMEM_WORDS)) state_next = ERROR;
                    else if (len_full == 16'd0)          state_next = CHECK;
                    else                                 state_next = DATA;
                end
                DATA: begin
                    if (byte_cnt == 2'd3 && word_idx == word_count - 16'd1) state_next = CHECK;
                end
                CHECK:   state_next = (rx_shift == checksum) ? DONE : ERROR;
                default: state_next = state;
            endcase
        end
    end

    // State register, status outputs, word assembly and the imem write strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            core_reset        <= 1'b1;
            load_done         <= 1'b0;
            load_error        <= 1'b0;
            imem.imem_wr_en   <= 1'b0;
            imem.imem_wr_addr <= '0;
            imem.imem_wr_data <= '0;
            len_lo            <= '0;
            word_count        <= '0;
            word_idx          <= '0;
            byte_cnt          <= '0;
            word_buf          <= '0;
            checksum          <= '0;
            tmo_cnt           <= '0;
        end else begin
            state           <= state_next;
            imem.imem_wr_en <= 1'b0;
            load_done       <= (state_next == DONE);
            load_error      <= (state_next == ERROR);
            core_reset      <= (state_next != DONE);

            if (rx_valid || (state_next != state) || !active) tmo_cnt <= '0;
            else                                              tmo_cnt <= tmo_cnt + 32'd1;

            if (state_next == LEN_LO && state != LEN_LO) begin
                word_idx <= '0;
                byte_cnt <= '0;
                word_buf <= '0;
                checksum <= '0;
            end

            if (rx_valid && !timeout) begin
                case (state)
                    LEN_LO: len_lo     <= rx_shift;
                    LEN_HI: word_count <= len_full;
                    DATA: begin
                        word_buf <= {rx_shift, word_buf[31:8]};
                        checksum <= checksum ^ rx_shift;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            imem.imem_wr_en   <= 1'b1;
                            imem.imem_wr_addr <= {14'd0, word_idx, 2'b00};
                            imem.imem_wr_data <= {rx_shift, word_buf[31:8]};
                            word_idx          <= word_idx + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_imem_loader.sv
// Directed bench for uart_imem_loader: a byte-level frame model predicts writes and status,
// and a compare process checks the DUT against it every cycle.
module tb_uart_imem_loader;

    localparam int CLK_HZ     = 12000000;
    localparam int BAUD       = 1000000;
    localparam int IMEM_WORDS = 2048;
    localparam int TIMEOUT    = 1000;
    localparam int CPB        = CLK_HZ / BAUD;

    localparam int S_IDLE = 0, S_LEN_LO = 1, S_LEN_HI = 2, S_DATA = 3, S_CHECK = 4, S_DONE = 5, S_ERROR = 6;

    logic clk = 1'b0;
    logic reset;
    logic uart_rx;
    logic core_reset, load_done, load_error;

    uart_imem_loader_if imem_bus();

    uart_imem_loader #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .IMEM_WORDS(IMEM_WORDS), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .uart_rx(uart_rx), .core_reset(core_reset),
        .load_done(load_done), .load_error(load_error), .imem(imem_bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit stable = 1'b0;

    int          m_state;
    int          m_n, m_idx, m_bcnt;
    logic [7:0]  m_len_lo;
    logic [7:0]  m_chk;
    logic [31:0] m_word;
    logic [63:0] exp_q[$];
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    logic [7:0]  frame[$];

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
        end
    endtask

    task automatic model_reset();
        m_state = S_IDLE;
        m_n = 0; m_idx = 0; m_bcnt = 0;
        m_len_lo = 8'h00; m_chk = 8'h00; m_word = 32'h0;
        exp_q.delete();
    endtask

    // Frame rules at byte granularity; expected writes are queued before the byte goes on the wire
    task automatic model_byte(input logic [7:0] b, input bit stop_ok);
        if (!stop_ok) begin
            if (m_state >= S_LEN_LO && m_state <= S_CHECK) m_state = S_ERROR;
            return;
        end
        case (m_state)
            S_IDLE, S_ERROR: begin
                if (b == 8'hA5) begin
                    m_state = S_LEN_LO;
                    m_idx = 0; m_bcnt = 0; m_chk = 8'h00; m_word = 32'h0;
                end
            end
            S_LEN_LO: begin m_len_lo = b; m_state = S_LEN_HI; end
            S_LEN_HI: begin
                m_n = int'(b) * 256 + int'(m_len_lo);
                if (m_n > IMEM_WORDS) m_state = S_ERROR;
                else if (m_n == 0)    m_state = S_CHECK;
                else                  m_state = S_DATA;
            end
            S_DATA: begin
                m_word = m_word | (32'(b) << (8 * m_bcnt));
                m_chk  = m_chk ^ b;
                m_bcnt++;
                if (m_bcnt == 4) begin
                    exp_q.push_back({32'(m_idx * 4), m_word});
                    m_idx++; m_bcnt = 0; m_word = 32'h0;
                    if (m_idx == m_n) m_state = S_CHECK;
                end
            end
            S_CHECK: m_state = (b == m_chk) ? S_DONE : S_ERROR;
            default: ;
        endcase
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        stable = 1'b0;
        model_byte(b, stop_ok);
        uart_rx = 1'b0;
        wait_cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            wait_cycles(CPB);
        end
        uart_rx = stop_ok;
        wait_cycles(CPB);
        uart_rx = 1'b1;
        wait_cycles(4);
        stable = 1'b1;
    endtask

    task automatic apply_stimulus(input logic [7:0] bytes[$]);
        foreach (bytes[i]) send_byte(bytes[i], 1'b1);
    endtask

    task automatic do_reset();
        stable = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        model_reset();
        wait_cycles(2);
        reset = 1'b0;
        log_addr.delete();
        log_data.delete();
        wait_cycles(2);
        stable = 1'b1;
    endtask

    // Every write strobe must match the next modelled write; status must match whenever the line is quiet
    always @(negedge clk) begin
        if (imem_bus.imem_wr_en) begin
            log_addr.push_back(imem_bus.imem_wr_addr);
            log_data.push_back(imem_bus.imem_wr_data);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_write actual_addr=0x%08h actual_data=0x%08h expected=none",
                         imem_bus.imem_wr_addr, imem_bus.imem_wr_data);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check_output("wr_addr", imem_bus.imem_wr_addr, e[63:32]);
                check_output("wr_data", imem_bus.imem_wr_data, e[31:0]);
            end
        end
        if (stable && !reset) begin
            check_output("core_reset", 32'(core_reset), 32'(m_state != S_DONE));
            check_output("load_done",  32'(load_done),  32'(m_state == S_DONE));
            check_output("load_error", 32'(load_error), 32'(m_state == S_ERROR));
        end
    end

    initial begin
        reset   = 1'b1;
        uart_rx = 1'b1;
        model_reset();
        wait_cycles(3);
        check_output("rst_core_reset", 32'(core_reset), 32'd1);
        check_output("rst_load_done",  32'(load_done),  32'd0);
        check_output("rst_load_error", 32'(load_error), 32'd0);
        check_output("rst_wr_en",      32'(imem_bus.imem_wr_en), 32'd0);
        reset = 1'b0;
        wait_cycles(2);
        stable = 1'b1;

        // Two-word image with a correct checksum
        frame = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
        apply_stimulus(frame);
        check_output("t1_nwrites", 32'(log_addr.size()), 32'd2);
        if (log_addr.size() == 2) begin
            check_output("t1_addr0", log_addr[0], 32'h0000_0000);
            check_output("t1_data0", log_data[0], 32'h0000_0013);
            check_output("t1_addr1", log_addr[1], 32'h0000_0004);
            check_output("t1_data1", log_data[1], 32'h0010_0093);
        end
        check_output("t1_done",      32'(load_done),  32'd1);
        check_output("t1_core_rst",  32'(core_reset), 32'd0);

        // Bad checksum, then the valid frame recovers
        do_reset();
        frame[11] = 8'h91;
        apply_stimulus(frame);
        check_output("t2_nwrites",  32'(log_addr.size()), 32'd2);
        check_output("t2_error",    32'(load_error), 32'd1);
        check_output("t2_core_rst", 32'(core_reset), 32'd1);
        frame[11] = 8'h90;
        apply_stimulus(frame);
        check_output("t2_err_clr",  32'(load_error), 32'd0);
        check_output("t2_done",     32'(load_done),  32'd1);

        // Empty image and oversize length
        do_reset();
        frame = {8'hA5, 8'h00, 8'h00, 8'h00};
        apply_stimulus(frame);
        check_output("t3_empty_done", 32'(load_done), 32'd1);
        check_output("t3_empty_nwr",  32'(log_addr.size()), 32'd0);
        do_reset();
        frame = {8'hA5, 8'h01, 8'h08};
        apply_stimulus(frame);
        check_output("t3_len_error", 32'(load_error), 32'd1);
        check_output("t3_len_nwr",   32'(log_addr.size()), 32'd0);

        // Framing error in DATA, then a line glitch inside a good frame
        do_reset();
        frame = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00};
        apply_stimulus(frame);
        send_byte(8'h00, 1'b0);
        check_output("t4_ferr", 32'(load_error), 32'd1);
        frame = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93};
        apply_stimulus(frame);
        stable = 1'b0;
        uart_rx = 1'b0;
        wait_cycles(3);
        uart_rx = 1'b1;
        wait_cycles(30);
        stable = 1'b1;
        frame = {8'h00, 8'h10, 8'h00, 8'h90};
        apply_stimulus(frame);
        check_output("t4_glitch_done", 32'(load_done), 32'd1);
        check_output("t4_glitch_err",  32'(load_error), 32'd0);

        // Partial word followed by silence
        do_reset();
        frame = {8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33};
        apply_stimulus(frame);
        stable = 1'b0;
        wait_cycles(TIMEOUT + 5);
        m_state = S_ERROR;
        stable = 1'b1;
        check_output("t5_timeout_err", 32'(load_error), 32'd1);
        send_byte(8'h44, 1'b1);
        check_output("t5_nwrites", 32'(log_addr.size()), 32'd0);

        // Reset in the middle of DATA, then a fresh one-word image
        do_reset();
        frame = {8'hA5, 8'h01, 8'h00, 8'hAA, 8'hBB};
        apply_stimulus(frame);
        stable = 1'b0;
        reset = 1'b1;
        model_reset();
        wait_cycles(1);
        check_output("t6_core_reset", 32'(core_reset), 32'd1);
        check_output("t6_load_done",  32'(load_done),  32'd0);
        check_output("t6_load_error", 32'(load_error), 32'd0);
        check_output("t6_wr_en",      32'(imem_bus.imem_wr_en), 32'd0);
        check_output("t6_wr_addr",    imem_bus.imem_wr_addr, 32'h0);
        check_output("t6_wr_data",    imem_bus.imem_wr_data, 32'h0);
        reset = 1'b0;
        log_addr.delete();
        log_data.delete();
        wait_cycles(2);
        stable = 1'b1;
        frame = {8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
        apply_stimulus(frame);
        check_output("t6_nwrites", 32'(log_addr.size()), 32'd1);
        if (log_addr.size() == 1) begin
            check_output("t6_addr0", log_addr[0], 32'h0000_0000);
            check_output("t6_data0", log_data[0], 32'hDEAD_BEEF);
        end
        check_output("t6_done", 32'(load_done), 32'd1);
        check_output("pending_writes", 32'(exp_q.size()), 32'd0);

        stable = 1'b0;
        wait_cycles(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
